iterative_div_unit: RTL and testbench
=====================================

ITERATIVE_DIV_UNIT -- requirements
Module: iterative_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default XLEN (32), operand/result width; legal values 8..64, even.
REQ-002 SHALL have parameter EARLY_EXIT, default TRUE, enabling single-cycle completion of special cases.
REQ-003 clk_i  input  1  clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 dividend_i  input  DATA_WIDTH  dividend operand.
REQ-006 divisor_i  input  DATA_WIDTH  divisor operand.
REQ-007 operation_i  input  div_ops_e  DIV_/DIVU_/REM_/REMU_.
REQ-008 valid_i  input  1  request strobe; accepted only when state_o = FREE.
REQ-009 abort_i  input  1  kills the in-flight operation (pipeline flush).
REQ-010 result_o  output  DATA_WIDTH  quotient or remainder, registered.
REQ-011 valid_o  output  1  one-cycle pulse: result_o is valid.
REQ-012 divide_by_zero_o  output  1  qualifies valid_o; divisor was zero.
REQ-013 state_o  output  fu_state_e  FREE when able to accept, BUSY otherwise.

Function
REQ-014 FSM states IDLE, PREPARE, DIVIDE, RESTORE; state_o = FREE only in IDLE.
REQ-015 IDLE: valid_i=1 and abort_i=0 captures operands and operation -> PREPARE (normal case).
REQ-016 PREPARE (1 cycle): absolute values for signed ops; load iteration counter with DATA_WIDTH-1 -> DIVIDE.
REQ-017 DIVIDE: restoring radix-2, one quotient bit per cycle, counter counts down; at counter 0 -> RESTORE.
REQ-018 RESTORE (1 cycle): quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); load result_o, pulse valid_o -> IDLE.
REQ-019 Normal-case latency: valid_o high exactly DATA_WIDTH+2 cycles after the accepting edge.
REQ-020 Divisor zero: DIV_/DIVU_ give all ones, REM_/REMU_ give dividend, divide_by_zero_o=1 with valid_o.
REQ-021 Signed overflow (dividend = most negative, divisor = -1, DIV_/REM_): DIV_ gives dividend, REM_ gives 0.
REQ-022 EARLY_EXIT=TRUE: cases REQ-020/021 complete with valid_o 1 cycle after acceptance, FSM stays IDLE; EARLY_EXIT=FALSE: they traverse full latency with the same results.
REQ-023 valid_i while BUSY SHALL be ignored (no queueing).
REQ-024 abort_i while BUSY: -> IDLE on next edge, no valid_o, result_o unchanged.
REQ-025 abort_i and valid_i together in IDLE: abort wins, request not accepted.
REQ-026 abort_i in the RESTORE cycle: abort wins, no valid_o.
REQ-027 New request SHALL be accepted in the same cycle valid_o is high (back-to-back).
REQ-028 result_o and divide_by_zero_o hold until the next completion.
REQ-029 Internal widths: partial remainder DATA_WIDTH+1 bits; counter $clog2(DATA_WIDTH) bits; no truncation of the most-negative operand's absolute value.

Reset
REQ-030 rst_i asserted: FSM -> IDLE, result_o=0, valid_o=0, divide_by_zero_o=0, state_o=FREE, counter=0, immediately (asynchronously).
REQ-031 Reset mid-operation discards the operation; no valid_o after release.

Structure
REQ-032 FSM enum div_fsm_e (IDLE, PREPARE, DIVIDE, RESTORE) SHALL be added to MGT_01_PACKAGE; div_ops_e and fu_state_e reused from it.
REQ-033 Single module, no sub-module; sign-fixup logic is local.

Verification (DATA_WIDTH=32 unless stated)
REQ-034 DIV_ 100/7 -> result_o=14 at accept+34; REM_ 100/7 -> 2.
REQ-035 DIV_ -100/7 -> 0xFFFFFFF2; REM_ -> 0xFFFFFFFE; DIVU_ 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU_ -> 1.
REQ-036 DIV_ 5/0 -> 0xFFFFFFFF, divide_by_zero_o=1 at accept+1; REM_ 0x80000000/-1 -> 0 at accept+1; EARLY_EXIT=FALSE -> same values at accept+34.
REQ-037 Abort at accept+10 -> no valid_o, state_o FREE next cycle; new DIVU_ 9/3 -> 3 at its accept+34.
REQ-038 rst_i pulse at accept+5 -> outputs zero immediately, no valid_o afterwards; back-to-back DIV_ requests each produce valid_o 34 cycles apart.
REQ-039 DATA_WIDTH=16: DIV_ 0x8000/0xFFFF -> 0x8000 at accept+1; REMU_ 1000/33 -> 10 at accept+18.

Source files
------------

// File: rtl/iterative_div_unit_pkg.sv
// Shared types for the functional units: operation codes, unit occupancy
// state and the divider FSM encoding.
package mgt_01_package;

   localparam int unsigned XLEN = 32;

   localparam bit TRUE  = 1'b1;
   localparam bit FALSE = 1'b0;

   typedef enum logic [1:0] {
      DIV_  = 2'd0,
      DIVU_ = 2'd1,
      REM_  = 2'd2,
      REMU_ = 2'd3
   } div_ops_e;

   typedef enum logic {
      FREE = 1'b0,
      BUSY = 1'b1
   } fu_state_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PREPARE = 2'd1,
      DIVIDE  = 2'd2,
      RESTORE = 2'd3
   } div_fsm_e;

   function automatic logic is_signed_op(input div_ops_e op);
      return (op == DIV_) || (op == REM_);
   endfunction

   function automatic logic is_rem_op(input div_ops_e op);
      return (op == REM_) || (op == REMU_);
   endfunction

endpackage

// File: rtl/iterative_div_unit.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle, signed and
// unsigned quotient/remainder, with optional single-cycle handling of divide
// by zero and signed overflow.
module iterative_div_unit
   import mgt_01_package::*;
#(
   parameter int unsigned DATA_WIDTH = XLEN,
   parameter bit          EARLY_EXIT = TRUE
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] dividend_i,
   input  logic [DATA_WIDTH-1:0] divisor_i,
   input  div_ops_e              operation_i,
   input  logic                  valid_i,
   input  logic                  abort_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  valid_o,
   output logic                  divide_by_zero_o,
   output fu_state_e             state_o
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   div_fsm_e              state_q, state_d;
   div_ops_e              op_q;
   logic [DATA_WIDTH-1:0] dividend_q, divisor_q;
   logic [DATA_WIDTH-1:0] quo_q, dvs_q;
   logic [DATA_WIDTH:0]   rem_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  dz_q, ovf_q, early_q;

   logic                  dz_in, ovf_in, accept;
   logic                  sgn_dd, sgn_dv, op_rem;
   logic [DATA_WIDTH-1:0] abs_dd, abs_dv;
   logic [DATA_WIDTH:0]   rem_shift, rem_diff;
   logic [DATA_WIDTH-1:0] quo_fix, rem_fix, special_res, final_res;

   // Request decode: special cases are detected on the raw operands
   always_comb begin
      dz_in  = (divisor_i == '0);
      ovf_in = is_signed_op(operation_i) && (dividend_i == MOST_NEG) && (divisor_i == '1);
      accept = (state_q == IDLE) && valid_i && !abort_i;
   end

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; abort always returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && !(EARLY_EXIT && (dz_in || ovf_in))) state_d = PREPARE;
         PREPARE: state_d = abort_i ? IDLE : DIVIDE;
         DIVIDE:  if (abort_i)          state_d = IDLE;
                  else if (cnt_q == '0) state_d = RESTORE;
         RESTORE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      state_o = (state_q == IDLE) ? FREE : BUSY;
   end

   // Datapath arithmetic: magnitudes, one restoring step, sign fix-up
   always_comb begin
      op_rem    = is_rem_op(op_q);
      sgn_dd    = is_signed_op(op_q) && dividend_q[DATA_WIDTH-1];
      sgn_dv    = is_signed_op(op_q) && divisor_q[DATA_WIDTH-1];
      abs_dd    = sgn_dd ? -dividend_q : dividend_q;
      abs_dv    = sgn_dv ? -divisor_q  : divisor_q;
      rem_shift = (rem_q << 1) | {{DATA_WIDTH{1'b0}}, quo_q[DATA_WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, dvs_q};
      quo_fix   = (sgn_dd ^ sgn_dv) ? -quo_q : quo_q;
      rem_fix   = sgn_dd ? -rem_q[DATA_WIDTH-1:0] : rem_q[DATA_WIDTH-1:0];
      if (dz_q) special_res = op_rem ? dividend_q : '1;
      else      special_res = op_rem ? '0 : dividend_q;
      if (dz_q || ovf_q) final_res = special_res;
      else               final_res = op_rem ? rem_fix : quo_fix;
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q             <= DIV_;
         dividend_q       <= '0;
         divisor_q        <= '0;
         quo_q            <= '0;
         dvs_q            <= '0;
         rem_q            <= '0;
         cnt_q            <= '0;
         dz_q             <= 1'b0;
         ovf_q            <= 1'b0;
         early_q          <= 1'b0;
         result_o         <= '0;
         valid_o          <= 1'b0;
         divide_by_zero_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         early_q <= EARLY_EXIT && accept && (dz_in || ovf_in);
         case (state_q)
            IDLE: begin
               // An early-exit request finishes one cycle after capture while
               // the FSM stays FREE, so its result uses the operands captured
               // last cycle even if a new request is captured on this edge.
               if (early_q && !abort_i) begin
                  result_o         <= special_res;
                  divide_by_zero_o <= dz_q;
                  valid_o          <= 1'b1;
               end
               if (accept) begin
                  op_q       <= operation_i;
                  dividend_q <= dividend_i;
                  divisor_q  <= divisor_i;
                  dz_q       <= dz_in;
                  ovf_q      <= ovf_in;
               end
            end
            PREPARE: begin
               quo_q <= abs_dd;
               dvs_q <= abs_dv;
               rem_q <= '0;
               cnt_q <= CNT_W'(DATA_WIDTH - 1);
            end
            DIVIDE: begin
               if (!abort_i) begin
                  rem_q <= rem_diff[DATA_WIDTH] ? rem_shift : rem_diff;
                  quo_q <= {quo_q[DATA_WIDTH-2:0], ~rem_diff[DATA_WIDTH]};
                  if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
               end
            end
            RESTORE: begin
               if (!abort_i) begin
                  result_o         <= final_res;
                  divide_by_zero_o <= dz_q;
                  valid_o          <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_div_unit.sv
// Directed bench for iterative_div_unit: 32-bit with and without early exit,
// plus a 16-bit instance.
module tb_iterative_div_unit;
   import mgt_01_package::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] dividend, divisor;
   div_ops_e    op;
   logic        va, vb, vc, abort;

   logic [31:0] ra, rb;
   logic [15:0] rc;
   logic        vo_a, vo_b, vo_c, dz_a, dz_b, dz_c;
   fu_state_e   st_a, st_b, st_c;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   iterative_div_unit #(.DATA_WIDTH(32), .EARLY_EXIT(1'b1)) dut_a (
      .clk_i(clk), .rst_i(rst), .dividend_i(dividend), .divisor_i(divisor),
      .operation_i(op), .valid_i(va), .abort_i(abort), .result_o(ra),
      .valid_o(vo_a), .divide_by_zero_o(dz_a), .state_o(st_a));

   iterative_div_unit #(.DATA_WIDTH(32), .EARLY_EXIT(1'b0)) dut_b (
      .clk_i(clk), .rst_i(rst), .dividend_i(dividend), .divisor_i(divisor),
      .operation_i(op), .valid_i(vb), .abort_i(abort), .result_o(rb),
      .valid_o(vo_b), .divide_by_zero_o(dz_b), .state_o(st_b));

   iterative_div_unit #(.DATA_WIDTH(16), .EARLY_EXIT(1'b1)) dut_c (
      .clk_i(clk), .rst_i(rst), .dividend_i(dividend[15:0]), .divisor_i(divisor[15:0]),
      .operation_i(op), .valid_i(vc), .abort_i(abort), .result_o(rc),
      .valid_o(vo_c), .divide_by_zero_o(dz_c), .state_o(st_c));

   function automatic logic [31:0] res_of(input int s);
      return (s == 0) ? ra : (s == 1) ? rb : {16'h0, rc};
   endfunction

   function automatic logic vo_of(input int s);
      return (s == 0) ? vo_a : (s == 1) ? vo_b : vo_c;
   endfunction

   function automatic logic dz_of(input int s);
      return (s == 0) ? dz_a : (s == 1) ? dz_b : dz_c;
   endfunction

   function automatic fu_state_e st_of(input int s);
      return (s == 0) ? st_a : (s == 1) ? st_b : st_c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one request; returns 1ns after the accepting edge
   task automatic start(input int s, input div_ops_e o, input logic [31:0] dd, input logic [31:0] dv);
      @(negedge clk);
      op = o; dividend = dd; divisor = dv;
      va = (s == 0); vb = (s == 1); vc = (s == 2);
      @(posedge clk);
      #1;
      va = 1'b0; vb = 1'b0; vc = 1'b0;
   endtask

   // Edges until valid_o is seen (0 = not seen within the budget)
   task automatic wait_valid(input int s, output int lat);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(posedge clk);
         #1;
         if (vo_of(s)) begin
            lat = n;
            break;
         end
      end
   endtask

   // Counts valid_o pulses over a window where none may occur
   task automatic no_valid(input int s, input string tag);
      int seen;
      seen = 0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         #1;
         if (vo_of(s)) seen++;
      end
      chk(tag, 64'(seen), 64'd0);
   endtask

   task automatic do_op(input int s, input div_ops_e o, input logic [31:0] dd, input logic [31:0] dv,
                        input logic [31:0] exp_res, input logic exp_dz, input int exp_lat, input string tag);
      int lat;
      start(s, o, dd, dv);
      if (exp_lat == 1) chk({tag, "_free"}, 64'(st_of(s)), 64'(FREE));
      wait_valid(s, lat);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, 64'(res_of(s)), 64'(exp_res));
      chk({tag, "_dz"},  64'(dz_of(s)), 64'(exp_dz));
      @(posedge clk);
      #1;
      chk({tag, "_pulse"}, 64'(vo_of(s)), 64'd0);
   endtask

   initial begin
      int lat;
      rst = 1'b1; abort = 1'b0; va = 1'b0; vb = 1'b0; vc = 1'b0;
      op = DIV_; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_res",   64'(ra),   64'd0);
      chk("rst_valid", 64'(vo_a), 64'd0);
      chk("rst_dz",    64'(dz_a), 64'd0);
      chk("rst_state", 64'(st_a), 64'(FREE));
      @(negedge clk);
      rst = 1'b0;

      // Normal signed/unsigned arithmetic
      do_op(0, DIV_,  32'd100,       32'd7,          32'd14,         1'b0, 34, "div_100_7");
      do_op(0, REM_,  32'd100,       32'd7,          32'd2,          1'b0, 34, "rem_100_7");
      do_op(0, DIV_,  -32'sd100,     32'd7,          32'hFFFF_FFF2,  1'b0, 34, "div_m100_7");
      do_op(0, REM_,  -32'sd100,     32'd7,          32'hFFFF_FFFE,  1'b0, 34, "rem_m100_7");
      do_op(0, DIVU_, 32'hFFFF_FFFF, 32'd2,          32'h7FFF_FFFF,  1'b0, 34, "divu_max_2");
      do_op(0, REMU_, 32'hFFFF_FFFF, 32'd2,          32'd1,          1'b0, 34, "remu_max_2");
      do_op(0, DIV_,  -32'sd7,       32'd2,          32'hFFFF_FFFD,  1'b0, 34, "div_m7_2");
      do_op(0, REM_,  32'd7,         -32'sd2,        32'd1,          1'b0, 34, "rem_7_m2");
      do_op(0, DIV_,  32'h8000_0000, 32'd2,          32'hC000_0000,  1'b0, 34, "div_min_2");
      do_op(0, DIV_,  32'h8000_0000, 32'd1,          32'h8000_0000,  1'b0, 34, "div_min_1");

      // Special cases with early exit
      do_op(0, DIV_,  32'd5,         32'd0,          32'hFFFF_FFFF,  1'b1, 1,  "ee_div_5_0");
      do_op(0, REM_,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0, 1,  "ee_rem_ovf");
      do_op(0, DIV_,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1,  "ee_div_ovf");
      do_op(0, REMU_, 32'd7,         32'd0,          32'd7,          1'b1, 1,  "ee_remu_7_0");
      do_op(0, DIVU_, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0, 34, "divu_min_max");

      // Special cases without early exit
      do_op(1, DIV_,  32'd5,         32'd0,          32'hFFFF_FFFF,  1'b1, 34, "ne_div_5_0");
      do_op(1, REM_,  32'h8000_0000, 32'hFFFF_FFFF,  32'd0,          1'b0, 34, "ne_rem_ovf");
      do_op(1, DIV_,  -32'sd5,       32'd0,          32'hFFFF_FFFF,  1'b1, 34, "ne_div_m5_0");
      do_op(1, REM_,  -32'sd5,       32'd0,          32'hFFFF_FFFB,  1'b1, 34, "ne_rem_m5_0");

      // 16-bit instance
      do_op(2, DIV_,  32'h0000_8000, 32'h0000_FFFF,  32'h0000_8000,  1'b0, 1,  "w16_div_ovf");
      do_op(2, REMU_, 32'd1000,      32'd33,         32'd10,         1'b0, 18, "w16_remu");

      // Abort mid-operation
      do_op(0, DIVU_, 32'd9, 32'd2, 32'd4, 1'b0, 34, "pre_abort");
      start(0, DIVU_, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_state", 64'(st_a), 64'(FREE));
      chk("abort_res",   64'(ra),   64'd4);
      chk("abort_valid", 64'(vo_a), 64'd0);
      no_valid(0, "abort_no_valid");
      do_op(0, DIVU_, 32'd9, 32'd3, 32'd3, 1'b0, 34, "post_abort");

      // Abort and valid together in IDLE
      @(negedge clk);
      op = DIV_; dividend = 32'd100; divisor = 32'd7; va = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1;
      va = 1'b0; abort = 1'b0;
      chk("abort_wins_state", 64'(st_a), 64'(FREE));
      no_valid(0, "abort_wins_no_valid");

      // Request while busy is ignored
      start(0, DIV_, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      @(negedge clk);
      op = DIVU_; dividend = 32'd9; divisor = 32'd3; va = 1'b1;
      @(posedge clk);
      #1;
      va = 1'b0;
      wait_valid(0, lat);
      chk("busy_ign_lat", 64'(lat), 64'd30);
      chk("busy_ign_res", 64'(ra),  64'd14);
      no_valid(0, "busy_ign_no_second");

      // Back-to-back: new request presented while valid_o is high
      start(0, DIV_, 32'd100, 32'd7);
      wait_valid(0, lat);
      chk("b2b_first_lat", 64'(lat), 64'd34);
      chk("b2b_first_res", 64'(ra),  64'd14);
      @(negedge clk);
      op = DIV_; dividend = -32'sd100; divisor = 32'd7; va = 1'b1;
      @(posedge clk);
      #1;
      va = 1'b0;
      chk("b2b_accepted", 64'(st_a), 64'(BUSY));
      wait_valid(0, lat);
      chk("b2b_second_lat", 64'(lat), 64'd34);
      chk("b2b_second_res", 64'(ra),  64'hFFFF_FFF2);

      // Asynchronous reset mid-operation
      do_op(0, DIV_, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, "pre_rst");
      start(0, DIV_, 32'd100, 32'd7);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_res",   64'(ra),   64'd0);
      chk("mid_rst_valid", 64'(vo_a), 64'd0);
      chk("mid_rst_dz",    64'(dz_a), 64'd0);
      chk("mid_rst_state", 64'(st_a), 64'(FREE));
      @(negedge clk);
      rst = 1'b0;
      no_valid(0, "mid_rst_no_valid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
